// File: rtl/proc_pkg.sv
// Shared processor definitions: default operand/address/opcode widths,
// the hazard-stall counter width and a saturating increment helper.
package proc_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int OP_WIDTH_DEF   = 6;
    localparam int STALL_CNT_W    = 16;

    typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic stall_cnt_t sat_inc(input stall_cnt_t v);
        return (v == '1) ? v : v + stall_cnt_t'(1);
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
// A bit is set when a writing instruction issues and cleared at writeback;
// when both hit the same register in one cycle the set wins, because the
// newly issued instruction is the one that owns the register afterwards.
module scoreboard
    import proc_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] q1_addr,
    input  logic [ADDR_WIDTH-1:0] q2_addr,
    input  logic [ADDR_WIDTH-1:0] q3_addr,
    output logic                  q1_pend,
    output logic                  q2_pend,
    output logic                  q3_pend
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Next pending vector: clear first, then set so that set has priority.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    // Pending-bit storage, all registers free after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign q1_pend = pending_q[q1_addr];
    assign q2_pend = pending_q[q2_addr];
    assign q3_pend = pending_q[q3_addr];

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads the register file, checks RAW/WAW hazards
// against the scoreboard and hands operands to execute through a
// one-entry valid/ready output register.
// Optional feature: define OPERAND_STAGE_BYPASS_EN to forward writeback
// data straight into the operands instead of stalling in the writeback cycle.
module operand_stage
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_rs1,
    input  logic [ADDR_WIDTH-1:0]  in_rs2,
    input  logic [ADDR_WIDTH-1:0]  in_rd,
    input  logic                   in_wr,
    input  logic [OP_WIDTH-1:0]    in_op,
    output logic [ADDR_WIDTH-1:0]  rf_addrA,
    output logic [ADDR_WIDTH-1:0]  rf_addrB,
    input  logic [DATA_WIDTH-1:0]  rf_a,
    input  logic [DATA_WIDTH-1:0]  rf_b,
    input  logic                   wb_valid,
    input  logic [ADDR_WIDTH-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_a,
    output logic [DATA_WIDTH-1:0]  out_b,
    output logic [ADDR_WIDTH-1:0]  out_rd,
    output logic                   out_wr,
    output logic [OP_WIDTH-1:0]    out_op,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic                   pend_rs1;
    logic                   pend_rs2;
    logic                   pend_rd;
    logic                   byp_a;
    logic                   byp_b;
    logic                   haz_rs1;
    logic                   haz_rs2;
    logic                   hazard;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  opnd_a;
    logic [DATA_WIDTH-1:0]  opnd_b;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_a_q,     out_a_d;
    logic [DATA_WIDTH-1:0]  out_b_q,     out_b_d;
    logic [ADDR_WIDTH-1:0]  out_rd_q,    out_rd_d;
    logic                   out_wr_q,    out_wr_d;
    logic [OP_WIDTH-1:0]    out_op_q,    out_op_d;
    stall_cnt_t             stall_cnt_q, stall_cnt_d;

    // Register-file read ports follow the decoded sources directly.
    assign rf_addrA = in_rs1;
    assign rf_addrB = in_rs2;

    scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept && in_wr),
        .set_addr (in_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .q1_addr  (in_rs1),
        .q2_addr  (in_rs2),
        .q3_addr  (in_rd),
        .q1_pend  (pend_rs1),
        .q2_pend  (pend_rs2),
        .q3_pend  (pend_rd)
    );

`ifdef OPERAND_STAGE_BYPASS_EN
    // A source matching this cycle's writeback takes the writeback data.
    assign byp_a = wb_valid && (wb_addr == in_rs1);
    assign byp_b = wb_valid && (wb_addr == in_rs2);
`else
    // No forwarding: sources always come from the register file.
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign opnd_a  = byp_a ? wb_data : rf_a;
    assign opnd_b  = byp_b ? wb_data : rf_b;

    // A pending source is only safe when it is being forwarded this cycle;
    // a pending destination (WAW) always stalls.
    assign haz_rs1 = pend_rs1 && !byp_a;
    assign haz_rs2 = pend_rs2 && !byp_b;
    assign hazard  = in_valid && (haz_rs1 || haz_rs2 || (in_wr && pend_rd));

    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register next state: load on accept, drain on out_ready, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;
        out_wr_d    = out_wr_q;
        out_op_d    = out_op_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_rd_d    = in_rd;
            out_wr_d    = in_wr;
            out_op_d    = in_op;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && !in_ready) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    // Output register and stall counter; reset discards any in-flight operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_wr_q    <= 1'b0;
            out_op_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
            out_wr_q    <= out_wr_d;
            out_op_q    <= out_op_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_wr    = out_wr_q;
    assign out_op    = out_op_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage with a fixed-content register-file model.
// Expectations follow OPERAND_STAGE_BYPASS_EN when it is defined.
module tb_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wr;
    logic [5:0]  in_op;
    logic [4:0]  rf_addrA, rf_addrB;
    logic [31:0] rf_a, rf_b;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;
    logic        out_wr;
    logic [5:0]  out_op;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Register-file contents: two fixed words, everything else C000_00xx.
    function automatic logic [31:0] rf_val(input logic [4:0] a);
        case (a)
            5'd4:    return 32'h0960_1050;
            5'd5:    return 32'h0A78_00D0;
            default: return 32'hC000_0000 | {27'd0, a};
        endcase
    endfunction

    assign rf_a = rf_val(rf_addrA);
    assign rf_b = rf_val(rf_addrB);

    operand_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .in_op     (in_op),
        .rf_addrA  (rf_addrA),
        .rf_addrB  (rf_addrB),
        .rf_a      (rf_a),
        .rf_b      (rf_b),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .out_op    (out_op),
        .stall_cnt (stall_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic [5:0] op);
        in_valid = 1'b1;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_wr    = wr;
        in_op    = op;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_wr     = 1'b0;
        in_op     = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
        checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL reset_out_a got %h want 0", out_a); end
        checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL reset_out_b got %h want 0", out_b); end
        checks++; if (out_rd !== 5'h0 || out_wr !== 1'b0 || out_op !== 6'h0) begin
            errors++; $display("FAIL reset_out_ctl got rd=%h wr=%h op=%h want 0", out_rd, out_wr, out_op); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %h want 0", stall_cnt); end
        in_rs1 = 5'd5;
        in_rs2 = 5'd9;
        #1;
        checks++; if (rf_addrA !== 5'd5 || rf_addrB !== 5'd9) begin
            errors++; $display("FAIL rf_addr got %h/%h want 05/09", rf_addrA, rf_addrB); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 6'h11);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %h want 1", in_ready); end
        cyc();
        checks++; if (out_valid !== 1'b1 || out_a !== 32'hC000_0001 || out_b !== 32'hC000_0002) begin
            errors++; $display("FAIL b2b_first got v=%h a=%h b=%h want 1/C0000001/C0000002", out_valid, out_a, out_b); end
        checks++; if (out_rd !== 5'd3 || out_wr !== 1'b1 || out_op !== 6'h11) begin
            errors++; $display("FAIL b2b_first_ctl got rd=%h wr=%h op=%h want 03/1/11", out_rd, out_wr, out_op); end
        issue(5'd4, 5'd5, 5'd6, 1'b1, 6'h22);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %h want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_a !== 32'h0960_1050 || out_b !== 32'h0A78_00D0) begin
            errors++; $display("FAIL b2b_second got a=%h b=%h want 09601050/0A7800D0", out_a, out_b); end
        checks++; if (out_rd !== 5'd6 || out_op !== 6'h22 || stall_cnt !== 16'h0) begin
            errors++; $display("FAIL b2b_second_ctl got rd=%h op=%h cnt=%h want 06/22/0", out_rd, out_op, stall_cnt); end
        cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %h want 0", out_valid); end
    endtask

    task automatic test_raw_hazard();
        do_reset();
        issue(5'd1, 5'd2, 5'd3, 1'b1, 6'h01);
        cyc();
        issue(5'd3, 5'd2, 5'd8, 1'b0, 6'h02);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got ready=%h want 0", in_ready); end
        cyc();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL raw_cnt1 got %h want 1", stall_cnt); end
        wb_valid = 1'b1;
        wb_addr  = 5'd3;
        wb_data  = 32'h0000_00AA;
        #1;
`ifdef OPERAND_STAGE_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %h want 1", in_ready); end
        cyc();
        wb_valid = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_a !== 32'h0000_00AA || out_rd !== 5'd8) begin
            errors++; $display("FAIL raw_out got v=%h a=%h rd=%h want 1/000000AA/08", out_valid, out_a, out_rd); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL raw_cnt got %h want 1", stall_cnt); end
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_ready got %h want 0", in_ready); end
        cyc();
        wb_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready got %h want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_a !== 32'hC000_0003 || out_rd !== 5'd8) begin
            errors++; $display("FAIL raw_out got v=%h a=%h rd=%h want 1/C0000003/08", out_valid, out_a, out_rd); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL raw_cnt got %h want 2", stall_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        issue(5'd4, 5'd5, 5'd9, 1'b0, 6'h15);
        cyc();
        issue(5'd1, 5'd2, 5'd10, 1'b0, 6'h2A);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %h want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_a !== 32'h0960_1050 || out_b !== 32'h0A78_00D0
                          || out_rd !== 5'd9 || out_op !== 6'h15) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%h a=%h b=%h rd=%h op=%h want 1/09601050/0A7800D0/09/15",
                                   i, out_valid, out_a, out_b, out_rd, out_op); end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %h want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_a !== 32'hC000_0001 || out_rd !== 5'd10 || out_op !== 6'h2A) begin
            errors++; $display("FAIL bp_next got a=%h rd=%h op=%h want C0000001/0A/2A", out_a, out_rd, out_op); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_cnt got %h want 3", stall_cnt); end
    endtask

    task automatic test_set_clear_collision();
        do_reset();
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'h1234_5678;
        issue(5'd1, 5'd2, 5'd7, 1'b1, 6'h07);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %h want 1", in_ready); end
        cyc();
        wb_valid = 1'b0;
        issue(5'd7, 5'd1, 5'd12, 1'b0, 6'h08);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL coll_pending7 got ready=%h want 0", in_ready); end
        cyc();
        checks++; if (in_ready !== 1'b0 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL coll_still got ready=%h cnt=%h want 0/1", in_ready, stall_cnt); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd3, 1'b1, 6'h03);
        cyc();
        issue(5'd3, 5'd2, 5'd4, 1'b0, 6'h04);
        cyc();
        checks++; if (stall_cnt !== 16'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rms_pre got cnt=%h v=%h want 1/1", stall_cnt, out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'h0 || out_a !== 32'h0) begin
            errors++; $display("FAIL rms_reset got v=%h cnt=%h a=%h want 0/0/0", out_valid, stall_cnt, out_a); end
        cyc();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rms_ready got %h want 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_a !== 32'hC000_0003 || stall_cnt !== 16'h0) begin
            errors++; $display("FAIL rms_accept got v=%h a=%h cnt=%h want 1/C0000003/0", out_valid, out_a, stall_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd3, 1'b0, 6'h00);
        cyc();
        issue(5'd4, 5'd5, 5'd6, 1'b0, 6'h01);
        repeat (65534) cyc();
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_edge got %h want FFFE", stall_cnt); end
        cyc();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_max got %h want FFFF", stall_cnt); end
        repeat (4465) cyc();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want FFFF", stall_cnt); end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_backpressure();
        test_set_clear_collision();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-003 SHALL have parameter OP_WIDTH, default 6, opaque opcode width passed through.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk, input, 1, clock, all state on posedge; rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have these ports:
- in_valid  in  1  issue request from decode
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2, in_rd  in  ADDR_WIDTH  source and destination addresses
- in_wr  in  1  instruction writes in_rd
- in_op  in  OP_WIDTH  opcode
- rf_addrA, rf_addrB  out  ADDR_WIDTH  register-file read addresses
- rf_a, rf_b  in  DATA_WIDTH  register-file read data
- wb_valid  in  1  writeback this cycle
- wb_addr  in  ADDR_WIDTH  writeback address
- wb_data  in  DATA_WIDTH  writeback data
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_a, out_b  out  DATA_WIDTH  operands
- out_rd  out  ADDR_WIDTH  destination
- out_wr  out  1  write flag
- out_op  out  OP_WIDTH  opcode
- stall_cnt  out  16  saturating hazard-stall counter

Function
REQ-006 SHALL drive rf_addrA=in_rs1 and rf_addrB=in_rs2 combinationally; rf_a/rf_b SHALL be valid in the same cycle.
REQ-007 SHALL keep a scoreboard of one pending bit per register.
REQ-008 SHALL flag a hazard when in_valid and any of these holds: rs1 pending; rs2 pending; in_wr and rd pending (WAW). A source that wb_valid clears in the same cycle is not a hazard only when bypass is enabled.
REQ-009 SHALL assert in_ready = !hazard && (!out_valid || out_ready).
REQ-010 SHALL, on accept (in_valid && in_ready), register out_a, out_b, out_rd, out_wr and out_op at the next posedge, set out_valid=1, and, if in_wr, set the pending bit of in_rd; latency is exactly 1 cycle.
REQ-011 SHALL clear out_valid when out_ready=1 and no new accept occurs; SHALL hold all out_* stable while out_valid && !out_ready.
REQ-012 SHALL clear pending[wb_addr] on wb_valid; when wb_valid clears and an accept sets the same register in one cycle, set SHALL win.
REQ-013 SHALL increment stall_cnt each cycle in_valid && !in_ready, saturating at 16'hFFFF with no wrap.
REQ-014 SHALL ignore wb_valid for a register whose pending bit is clear, apart from bypass data selection.

Reset
REQ-015 SHALL, while rst_n=0, force: out_valid=0; out_a=0, out_b=0, out_rd=0, out_wr=0, out_op=0; scoreboard all 0; stall_cnt=0.
REQ-016 SHALL discard any in-flight operand on reset assertion mid-operation; the first accept is possible in the first cycle after rst_n rises.

Configuration
REQ-017 SHALL, with OPERAND_STAGE_BYPASS_EN defined, select wb_data instead of rf_a or rf_b when wb_valid and wb_addr equals rs1 or rs2, with no hazard stall for that source.
REQ-018 SHALL, without OPERAND_STAGE_BYPASS_EN, stall while the source is pending, including the writeback cycle, and accept in the following cycle from register-file data.

Structure
REQ-019 SHALL take DATA_WIDTH, ADDR_WIDTH and OP_WIDTH defaults and the stall-counter width from shared package proc_pkg.
REQ-020 SHALL place the pending-bit array with its set/clear/query logic in sub-module scoreboard.

Verification
REQ-021 Bench SHALL cover back-to-back independent instructions: rs1=1, rs2=2, rd=3, then rs1=4, rs2=5, rd=6, out_ready=1 -> accepted on consecutive cycles, out_a=32'h0960_1050, out_b=32'h0A78_00D0, stall_cnt=0.
REQ-022 Bench SHALL cover a RAW hazard: issue rd=3 with in_wr, next rs1=3, wb_valid two cycles later with data 32'h0000_00AA -> with bypass, accept on the wb cycle with out_a=32'hAA and stall_cnt=1; without bypass, accept one cycle later and stall_cnt=2.
REQ-023 Bench SHALL cover backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0 and out_* unchanged; out_ready=1 -> next accept.
REQ-024 Bench SHALL cover set/clear collision: wb_valid on reg 7 and accept with rd=7, in_wr=1 in one cycle -> pending[7]=1 afterwards.
REQ-025 Bench SHALL cover reset mid-stall: rst_n=0 while stalled with out_valid=1 -> out_valid=0, stall_cnt=0, scoreboard clear, next cycle accepts rs1=3 without stall.
REQ-026 Bench SHALL cover counter saturation: preload a 70000-cycle permanent hazard -> stall_cnt=16'hFFFF and held there.
